// File: rtl/rm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rm_ctrl_pkg
// Brief    : Shared state encoding and parameter defaults for the cluster ctrl.
// Revision : 1.0
// ============================================================================
package rm_ctrl_pkg;

    localparam int c_SYM_W_DEF        = 8;
    localparam int c_NUM_LTL_DEF      = 11;
    localparam int c_FIFO_DEPTH_DEF   = 4;
    localparam int c_FLUSH_CYC_DEF    = 2;
    localparam int c_HALT_ON_VIOL_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rm_sym_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rm_sym_fifo
// Brief    : Power-of-two symbol buffer with synchronous clear and head output.
// Revision : 1.0
// ============================================================================
module rm_sym_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB tells full from empty when the indices coincide.
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                    (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
    assign w_push = push && !full && !clr;
    assign w_pop  = pop && !empty && !clr;
    assign head   = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/rm_cluster_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rm_cluster_ctrl
// Brief    : Feeds symbols to a runtime-monitor cluster and captures LTL
//            violations. Define RM_TIMESTAMP_EN to add the first_ts output.
// Revision : 1.0
// ============================================================================
module rm_cluster_ctrl
    import rm_ctrl_pkg::*;
#(
    parameter int SYM_W        = c_SYM_W_DEF,
    parameter int NUM_LTL      = c_NUM_LTL_DEF,
    parameter int FIFO_DEPTH   = c_FIFO_DEPTH_DEF,
    parameter int FLUSH_CYC    = c_FLUSH_CYC_DEF,
    parameter int HALT_ON_VIOL = c_HALT_ON_VIOL_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sym_valid,
    input  logic [SYM_W-1:0]           sym_data,
    output logic                       sym_ready,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       clear,
    output logic                       mon_run,
    output logic [SYM_W-1:0]           mon_symbols,
    output logic                       mon_reset,
    input  logic [NUM_LTL-1:0]         mon_viol,
    output logic [NUM_LTL-1:0]         viol_sticky,
    output logic                       viol_irq,
    output logic [$clog2(NUM_LTL)-1:0] first_id,
    output logic [15:0]                viol_count,
`ifdef RM_TIMESTAMP_EN
    output logic [31:0]                first_ts,
`endif
    output logic                       busy
);

    localparam int c_ID_W = $clog2(NUM_LTL);
    localparam int c_FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    state_t             r_state;
    logic               r_run_after;
    logic [c_FC_W-1:0]  r_flush_cnt;
    logic               r_mon_run;
    logic               r_mon_reset;
    logic [SYM_W-1:0]   r_mon_symbols;
    logic [NUM_LTL-1:0] r_viol_sticky;
    logic               r_viol_irq;
    logic [c_ID_W-1:0]  r_first_id;
    logic [15:0]        r_viol_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_hit;
    logic               w_halt_req;
    logic [SYM_W-1:0]   w_head;

    function automatic logic [c_ID_W-1:0] f_lowest_set(input logic [NUM_LTL-1:0] vec);
        f_lowest_set = '0;
        for (int i = NUM_LTL - 1; i >= 0; i--)
            if (vec[i]) f_lowest_set = c_ID_W'(i);
    endfunction

    assign w_hit      = ((r_state == ST_RUN) || (r_state == ST_HALT)) && (mon_viol != '0);
    assign w_halt_req = (HALT_ON_VIOL != 0) && (r_state == ST_RUN) && (mon_viol != '0);
    assign sym_ready  = !reset && !w_full && (r_state != ST_HALT);
    assign w_push     = sym_valid && sym_ready;
    // No issue on a cycle that is about to leave RUN, so mon_run never trails the state.
    assign w_pop      = (r_state == ST_RUN) && !w_empty && !clear && !stop && !w_halt_req;
    assign busy       = (r_state != ST_IDLE) || !w_empty;

    rm_sym_fifo #(
        .WIDTH (SYM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .push  (w_push),
        .pop   (w_pop),
        .din   (sym_data),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_run_after <= 1'b0;
            r_flush_cnt <= '0;
            r_mon_reset <= 1'b1;
        end else if (clear) begin
            r_state     <= ST_FLUSH;
            r_run_after <= 1'b0;
            r_flush_cnt <= c_FC_W'(FLUSH_CYC - 1);
            r_mon_reset <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!stop && start) begin
                        r_state     <= ST_FLUSH;
                        r_run_after <= 1'b1;
                        r_flush_cnt <= c_FC_W'(FLUSH_CYC - 1);
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        if (r_run_after) begin
                            r_state     <= ST_RUN;
                            r_mon_reset <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state     <= ST_IDLE;
                        r_mon_reset <= 1'b1;
                    end else if (w_halt_req) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (stop) begin
                        r_state     <= ST_IDLE;
                        r_mon_reset <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_mon_reset <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mon_run     <= 1'b0;
            r_mon_symbols <= '0;
        end else begin
            r_mon_run <= w_pop;
            if (w_pop) r_mon_symbols <= w_head;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_viol_sticky <= '0;
            r_viol_irq    <= 1'b0;
            r_first_id    <= '0;
            r_viol_count  <= '0;
        end else if (clear) begin
            r_viol_sticky <= '0;
            r_viol_irq    <= 1'b0;
            r_first_id    <= '0;
            r_viol_count  <= '0;
        end else if (w_hit) begin
            r_viol_sticky <= r_viol_sticky | mon_viol;
            r_viol_irq    <= 1'b1;
            if (r_viol_sticky == '0)      r_first_id   <= f_lowest_set(mon_viol);
            if (r_viol_count != 16'hFFFF) r_viol_count <= r_viol_count + 1'b1;
        end
    end

`ifdef RM_TIMESTAMP_EN
    logic [31:0] r_issue_cnt;
    logic [31:0] r_first_ts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issue_cnt <= '0;
            r_first_ts  <= '0;
        end else begin
            if (r_state == ST_FLUSH) r_issue_cnt <= '0;
            else if (w_pop)          r_issue_cnt <= r_issue_cnt + 1'b1;
            if (clear)                              r_first_ts <= '0;
            else if (w_hit && r_viol_sticky == '0)  r_first_ts <= r_issue_cnt;
        end
    end

    assign first_ts = r_first_ts;
`endif

    assign mon_run     = r_mon_run;
    assign mon_symbols = r_mon_symbols;
    assign mon_reset   = r_mon_reset;
    assign viol_sticky = r_viol_sticky;
    assign viol_irq    = r_viol_irq;
    assign first_id    = r_first_id;
    assign viol_count  = r_viol_count;

endmodule
`default_nettype wire

// File: tb/tb_rm_cluster_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rm_cluster_ctrl
// Brief    : Directed self-checking bench for rm_cluster_ctrl (RM_TIMESTAMP_EN aware).
// Revision : 1.0
// ============================================================================
module tb_rm_cluster_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        sym_valid, start, stop, clear;
    logic [7:0]  sym_data;
    logic [10:0] mon_viol;
    logic        sym_ready, mon_run, mon_reset, viol_irq, busy;
    logic [7:0]  mon_symbols;
    logic [10:0] viol_sticky;
    logic [3:0]  first_id;
    logic [15:0] viol_count;

    logic        start2;
    logic [10:0] mon_viol2;
    logic        sym_ready2, mon_run2, mon_reset2, viol_irq2, busy2;
    logic [7:0]  mon_symbols2;
    logic [10:0] viol_sticky2;
    logic [3:0]  first_id2;
    logic [15:0] viol_count2;
`ifdef RM_TIMESTAMP_EN
    logic [31:0] first_ts, first_ts2;
`endif

    int checks = 0;
    int errors = 0;
    int n_issued;
    logic found;

    always #5 clk = ~clk;

    rm_cluster_ctrl dut (
        .clk(clk), .reset(reset),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
        .start(start), .stop(stop), .clear(clear),
        .mon_run(mon_run), .mon_symbols(mon_symbols), .mon_reset(mon_reset),
        .mon_viol(mon_viol),
        .viol_sticky(viol_sticky), .viol_irq(viol_irq), .first_id(first_id),
        .viol_count(viol_count),
`ifdef RM_TIMESTAMP_EN
        .first_ts(first_ts),
`endif
        .busy(busy)
    );

    rm_cluster_ctrl #(.HALT_ON_VIOL(0)) dut2 (
        .clk(clk), .reset(reset),
        .sym_valid(1'b0), .sym_data(8'h00), .sym_ready(sym_ready2),
        .start(start2), .stop(1'b0), .clear(1'b0),
        .mon_run(mon_run2), .mon_symbols(mon_symbols2), .mon_reset(mon_reset2),
        .mon_viol(mon_viol2),
        .viol_sticky(viol_sticky2), .viol_irq(viol_irq2), .first_id(first_id2),
        .viol_count(viol_count2),
`ifdef RM_TIMESTAMP_EN
        .first_ts(first_ts2),
`endif
        .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; sym_valid = 1'b0; sym_data = 8'h00;
        start = 1'b0; stop = 1'b0; clear = 1'b0; mon_viol = '0;
        start2 = 1'b0; mon_viol2 = '0;
        cyc(2);
        chk("rst_sym_ready", sym_ready, 0);
        chk("rst_mon_reset", mon_reset, 1);
        chk("rst_mon_run", mon_run, 0);
        chk("rst_mon_symbols", mon_symbols, 0);
        chk("rst_viol_count", viol_count, 0);
        chk("rst_viol_irq", viol_irq, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0; #1;
        chk("ready_after_rst", sym_ready, 1);

        // start + two symbols: 2 FLUSH cycles, then A5, 3C on consecutive cycles
        start = 1'b1; sym_valid = 1'b1; sym_data = 8'hA5;
        cyc(1); start = 1'b0; sym_data = 8'h3C;
        chk("flush1_mon_reset", mon_reset, 1);
        cyc(1); sym_valid = 1'b0;
        chk("flush2_mon_reset", mon_reset, 1);
        chk("flush2_busy", busy, 1);
        cyc(1);
        chk("run_mon_reset", mon_reset, 0);
        chk("run_first_mon_run", mon_run, 0);
        cyc(1);
        chk("issue_a5_run", mon_run, 1);
        chk("issue_a5_sym", mon_symbols, 8'hA5);
        cyc(1);
        chk("issue_3c_run", mon_run, 1);
        chk("issue_3c_sym", mon_symbols, 8'h3C);
        cyc(1);
        chk("idle_issue_run", mon_run, 0);
        chk("hold_sym", mon_symbols, 8'h3C);

        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("stop_mon_reset", mon_reset, 1);
        chk("stop_busy", busy, 0);

        // Fill the buffer in IDLE: four accepts, fifth held
        for (int i = 0; i < 5; i++) begin
            sym_valid = 1'b1; sym_data = 8'h10 + 8'(i);
            chk($sformatf("fill_ready_%0d", i), sym_ready, (i < 4) ? 1 : 0);
            cyc(1);
        end
        chk("full_ready", sym_ready, 0);
        chk("full_busy", busy, 1);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(3);
        chk("drain_ready", sym_ready, 1);
        chk("drain_sym_0", mon_symbols, 8'h10);
        for (int k = 1; k < 5; k++) begin
            cyc(1);
            if (k == 1) sym_valid = 1'b0;
            chk($sformatf("drain_run_%0d", k), mon_run, 1);
            chk($sformatf("drain_sym_%0d", k), mon_symbols, 8'h10 + 8'(k));
        end
        cyc(1);
        chk("drain_done", mon_run, 0);

        // Violation in RUN halts next cycle
        chk("pre_viol_count", viol_count, 0);
        mon_viol = 11'h048; cyc(1); mon_viol = '0;
        chk("viol_sticky", viol_sticky, 11'h048);
        chk("viol_first_id", first_id, 3);
        chk("viol_count1", viol_count, 1);
        chk("viol_irq", viol_irq, 1);
        chk("halt_ready", sym_ready, 0);
        chk("halt_mon_reset", mon_reset, 0);
        mon_viol = 11'h001; cyc(1); mon_viol = '0;
        chk("halt_sticky_or", viol_sticky, 11'h049);
        chk("halt_first_id_kept", first_id, 3);
        chk("halt_count2", viol_count, 2);

        // clear + stop together in HALT: clear wins
        clear = 1'b1; stop = 1'b1; cyc(1); clear = 1'b0; stop = 1'b0;
        chk("clr_sticky", viol_sticky, 0);
        chk("clr_first_id", first_id, 0);
        chk("clr_count", viol_count, 0);
        chk("clr_irq", viol_irq, 0);
        chk("clr_flush1_busy", busy, 1);
        cyc(1);
        chk("clr_flush2_busy", busy, 1);
        cyc(1);
        chk("clr_idle_busy", busy, 0);
        chk("clr_idle_mon_reset", mon_reset, 1);
        chk("clr_idle_ready", sym_ready, 1);

        // clear empties a non-empty buffer
        sym_valid = 1'b1; sym_data = 8'h77; cyc(2); sym_valid = 1'b0;
        chk("pre_clr_busy", busy, 1);
        clear = 1'b1; cyc(1); clear = 1'b0; cyc(2);
        chk("clr_fifo_empty", busy, 0);

`ifdef RM_TIMESTAMP_EN
        start = 1'b1; sym_valid = 1'b1; sym_data = 8'h20;
        n_issued = 0; found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cyc(1); start = 1'b0;
            if (mon_run) n_issued++;
            if (n_issued == 6) begin
                mon_viol = 11'h004; found = 1'b1;
                break;
            end
        end
        chk("ts_sixth_issue_seen", found, 1);
        cyc(1); mon_viol = '0; sym_valid = 1'b0;
        chk("ts_first_ts", first_ts, 6);
        chk("ts_first_id", first_id, 2);
        stop = 1'b1; cyc(1); stop = 1'b0;
`endif

        // Reset in the middle of RUN
        start = 1'b1; cyc(1); start = 1'b0; cyc(2);
        sym_valid = 1'b1; sym_data = 8'h66;
        reset = 1'b1; #1;
        chk("midrst_mon_run", mon_run, 0);
        chk("midrst_mon_symbols", mon_symbols, 0);
        chk("midrst_mon_reset", mon_reset, 1);
        chk("midrst_ready", sym_ready, 0);
        chk("midrst_busy", busy, 0);
        sym_valid = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        cyc(2);
        chk("postrst_run", mon_run, 0);
        chk("postrst_busy", busy, 0);
        sym_valid = 1'b1; sym_data = 8'h5A; start = 1'b1;
        cyc(1); sym_valid = 1'b0; start = 1'b0;
        cyc(3);
        chk("postrst_issue_run", mon_run, 1);
        chk("postrst_issue_sym", mon_symbols, 8'h5A);

        // Saturating violation counter with HALT_ON_VIOL=0
        start2 = 1'b1; cyc(1); start2 = 1'b0; cyc(2);
        chk("sat_in_run", mon_reset2, 0);
        mon_viol2 = 11'h001;
        cyc(100);
        chk("sat_count_100", viol_count2, 100);
        cyc(69900);
        chk("sat_count_ffff", viol_count2, 16'hFFFF);
        chk("sat_no_halt", mon_reset2, 0);
        chk("sat_sticky", viol_sticky2, 11'h001);
        mon_viol2 = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rm_cluster_ctrl.md
RM_CLUSTER_CTRL -- requirements
Module: rm_cluster_ctrl

Interface
REQ-001 SHALL have parameter SYM_W, default 8, symbol width fed to the monitor cluster.
REQ-002 SHALL have parameter NUM_LTL, default 11, number of LTL violation lines from the cluster.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, symbol buffer depth (power of 2, >=2).
REQ-004 SHALL have parameter FLUSH_CYC, default 2, cycles mon_reset is held during FLUSH (>=1).
REQ-005 SHALL have parameter HALT_ON_VIOL, default 1, stop symbol issue on the first violation when 1.
REQ-006 SHALL have ports: clk  in  1  single clock; reset  in  1  asynchronous, active-high.
REQ-007 SHALL have ports: sym_valid in 1, sym_data in SYM_W, sym_ready out 1  (producer valid/ready handshake).
REQ-008 SHALL have ports: start in 1, stop in 1, clear in 1  (single-cycle control pulses).
REQ-009 SHALL have ports: mon_run out 1, mon_symbols out SYM_W, mon_reset out 1  (drive cluster run/symbols/reset).
REQ-010 SHALL have port mon_viol in NUM_LTL, with bit i = cluster ltl output i.
REQ-011 SHALL have ports: viol_sticky out NUM_LTL, viol_irq out 1, first_id out $clog2(NUM_LTL), viol_count out 16, busy out 1.

Function
REQ-012 SHALL implement FSM IDLE, FLUSH, RUN, HALT; control priority clear > stop > start.
REQ-013 SHALL: IDLE+start -> FLUSH with run_after=1; clear in any state -> FLUSH with run_after=0, FIFO emptied, viol_sticky/first_id/viol_count zeroed in that cycle.
REQ-014 SHALL hold FLUSH exactly FLUSH_CYC cycles, then go to RUN if run_after=1, else IDLE.
REQ-015 SHALL: stop in RUN or HALT -> IDLE next cycle, FIFO contents retained.
REQ-016 SHALL drive registered mon_reset=1 in IDLE and FLUSH, 0 in RUN and HALT.
REQ-017 SHALL: sym_ready = FIFO not full AND state != HALT; push when sym_valid&sym_ready; no push at full, no bypass at empty.
REQ-018 SHALL, in RUN with FIFO non-empty, pop one entry per cycle; popped value appears on registered mon_symbols with mon_run=1 the next cycle; minimum accept-to-issue latency 2 cycles.
REQ-019 SHALL hold mon_symbols at last issued value when mon_run=0; mon_run=0 outside RUN-issue cycles.
REQ-020 SHALL sample mon_viol only in RUN and HALT; viol_sticky |= mon_viol each sampled cycle.
REQ-021 SHALL, on the first sampled cycle with mon_viol!=0 while viol_sticky==0, load first_id with lowest set index.
REQ-022 SHALL increment viol_count by 1 per sampled cycle with mon_viol!=0, saturating at 16'hFFFF.
REQ-023 SHALL register viol_irq = |viol_sticky (level, cleared only by clear or reset).
REQ-024 SHALL, when HALT_ON_VIOL=1, go RUN -> HALT in the cycle after first nonzero sample; no pops in HALT.
REQ-025 SHALL assert busy when state != IDLE or FIFO non-empty.
REQ-026 SHALL: push and pop in same cycle leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-027 SHALL on reset: state IDLE, FIFO empty, run_after 0, mon_run 0, mon_symbols 0, mon_reset 1, viol_sticky 0, first_id 0, viol_count 0, viol_irq 0, sym_ready 0 during reset.
REQ-028 SHALL abandon any in-flight FLUSH/RUN on reset mid-operation with no residual pop or push.

Configuration
REQ-029 SHALL, with RM_TIMESTAMP_EN defined, add out port first_ts (32) = count of symbols issued since last FLUSH exit, captured with first_id; counter zeroed in FLUSH, wraps at 2^32.
REQ-030 SHALL, without RM_TIMESTAMP_EN, omit first_ts port and its counter.

Structure
REQ-031 SHALL place state enum and parameter defaults in package rm_ctrl_pkg.
REQ-032 SHALL implement buffer as sub-module rm_sym_fifo (push/pop/full/empty/head).

Verification
REQ-033 SHALL cover: reset, start, push 8'hA5,8'h3C -> mon_reset low after 2 FLUSH cycles, mon_run=1 with mon_symbols A5 then 3C on consecutive cycles.
REQ-034 SHALL cover: push 5 symbols with sym_ready observed, no pops (IDLE) -> sym_ready=0 after 4th accept, 5th held.
REQ-035 SHALL cover: mon_viol=11'h048 during RUN -> viol_sticky=048, first_id=3, viol_count=1, viol_irq=1, HALT next cycle, sym_ready=0.
REQ-036 SHALL cover: clear and stop same cycle in HALT -> FLUSH 2 cycles then IDLE, all stats zero, FIFO empty.
REQ-037 SHALL cover: mon_viol held nonzero 70000 cycles with HALT_ON_VIOL=0 -> viol_count saturates at FFFF.
REQ-038 SHALL cover (RM_TIMESTAMP_EN): violation on 6th issued symbol -> first_ts=6.
